// File: rtl/laser_interlock.sv
// laser_interlock: laser enable safety FSM with max-on limit, mandatory cooldown and fault latching.
// Define LASER_INTERLOCK_WDT_EN to add the heartbeat watchdog that faults the laser when heartbeats stop.
module laser_interlock #(
    parameter logic [31:0] MAX_ON_CYCLES   = 32'd50_000_000,
    parameter logic [31:0] COOLDOWN_CYCLES = 32'd10_000_000,
    parameter logic [23:0] WDT_CYCLES      = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       laser_ready,
    input  logic       en_req,
    input  logic       fault_n,
    input  logic       heartbeat,
    input  logic       clear_fault,
    output logic       laser_en,
    output logic       fault_latched,
    output logic [1:0] fault_code,
    output logic [2:0] state
);
    localparam logic [2:0] WAIT_RDY = 3'd0;
    localparam logic [2:0] IDLE     = 3'd1;
    localparam logic [2:0] ON       = 3'd2;
    localparam logic [2:0] FAULT    = 3'd3;
    localparam logic [2:0] COOLDOWN = 3'd4;
    // A zero parameter behaves as one: the limit compare then fires on the first cycle.
    localparam logic [31:0] MAX_ON_LIM = (MAX_ON_CYCLES == 32'd0) ? 32'd0 : MAX_ON_CYCLES - 32'd1;
    localparam logic [31:0] COOL_LIM   = (COOLDOWN_CYCLES == 32'd0) ? 32'd0 : COOLDOWN_CYCLES - 32'd1;

    logic [2:0]  state_q, state_d;
    logic        laser_en_q, laser_en_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic [31:0] on_cnt_q, on_cnt_d;
    logic [31:0] cool_cnt_q, cool_cnt_d;
    logic        wdt_exp;

`ifdef LASER_INTERLOCK_WDT_EN
    localparam logic [23:0] WDT_LIM = (WDT_CYCLES == 24'd0) ? 24'd0 : WDT_CYCLES - 24'd1;
    logic [23:0] wdt_cnt_q, wdt_cnt_d;
    assign wdt_exp = (wdt_cnt_q == WDT_LIM) && !heartbeat;
    always_comb wdt_cnt_d = (state_q != ON || heartbeat) ? 24'd0 : wdt_cnt_q + {23'd0, ~&wdt_cnt_q};
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) wdt_cnt_q <= 24'd0;
        else       wdt_cnt_q <= wdt_cnt_d;
`else
    logic [24:0] unused_wdt;
    assign unused_wdt = {heartbeat, WDT_CYCLES};
    assign wdt_exp    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            WAIT_RDY: state_d = laser_ready ? IDLE : WAIT_RDY;
            IDLE: begin
                if (!fault_n) begin
                    state_d      = FAULT;
                    fault_code_d = 2'd1;
                end else if (!laser_ready) state_d = WAIT_RDY;
                else if (en_req)           state_d = ON;
            end
            ON: begin
                if (!fault_n || wdt_exp || on_cnt_q == MAX_ON_LIM) begin
                    state_d      = FAULT;
                    fault_code_d = !fault_n ? 2'd1 : wdt_exp ? 2'd3 : 2'd2;
                end else if (!laser_ready) state_d = WAIT_RDY;
                else if (!en_req)          state_d = COOLDOWN;
            end
            FAULT: state_d = (clear_fault && fault_n && !en_req) ? COOLDOWN : FAULT;
            COOLDOWN: begin
                if (!fault_n) begin
                    state_d      = FAULT;
                    fault_code_d = 2'd1;
                end else if (!laser_ready)         state_d = WAIT_RDY;
                else if (cool_cnt_q == COOL_LIM)   state_d = IDLE;
            end
            default: begin
                state_d      = FAULT;
                fault_code_d = 2'd1;
            end
        endcase
        laser_en_d = (state_d == ON);
        on_cnt_d   = (state_q != ON) ? 32'd0 : on_cnt_q + {31'd0, ~&on_cnt_q};
        cool_cnt_d = (state_q != COOLDOWN) ? 32'd0 : cool_cnt_q + {31'd0, ~&cool_cnt_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= WAIT_RDY;
            laser_en_q   <= 1'b0;
            fault_code_q <= 2'd0;
            on_cnt_q     <= 32'd0;
            cool_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            laser_en_q   <= laser_en_d;
            fault_code_q <= fault_code_d;
            on_cnt_q     <= on_cnt_d;
            cool_cnt_q   <= cool_cnt_d;
        end
    end

    assign laser_en      = laser_en_q;
    assign fault_latched = (state_q == FAULT);
    assign fault_code    = fault_code_q;
    assign state         = state_q;
endmodule

// File: tb/tb_laser_interlock.sv
// tb_laser_interlock: directed scoreboard bench for laser_interlock with MAX_ON=100, COOLDOWN=20, WDT=10.
module tb_laser_interlock;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       laser_ready = 1'b0;
    logic       en_req = 1'b0;
    logic       fault_n = 1'b1;
    logic       heartbeat = 1'b0;
    logic       clear_fault = 1'b0;
    logic       laser_en;
    logic       fault_latched;
    logic [1:0] fault_code;
    logic [2:0] state;

    int n_cmp = 0;
    int n_fail = 0;
    logic [6:0] exp_q[$];

`ifdef LASER_INTERLOCK_WDT_EN
    localparam int WD_LEN = 14;
    localparam logic [1:0] WD_CODE = 2'd3;
`else
    localparam int WD_LEN = 100;
    localparam logic [1:0] WD_CODE = 2'd2;
`endif

    laser_interlock #(
        .MAX_ON_CYCLES(32'd100),
        .COOLDOWN_CYCLES(32'd20),
        .WDT_CYCLES(24'd10)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .laser_ready(laser_ready),
        .en_req(en_req),
        .fault_n(fault_n),
        .heartbeat(heartbeat),
        .clear_fault(clear_fault),
        .laser_en(laser_en),
        .fault_latched(fault_latched),
        .fault_code(fault_code),
        .state(state)
    );

    always #5 clk = ~clk;

    // Expected output word: {state, laser_en, fault_latched, fault_code}.
    function automatic logic [6:0] expect_word(input logic [2:0] s, input logic [1:0] c);
        return {s, s == 3'd2, s == 3'd3, c};
    endfunction

    task automatic check(input string tag);
        logic [6:0] e;
        logic [6:0] obs;
        e   = exp_q.pop_front();
        obs = {state, laser_en, fault_latched, fault_code};
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: got {state,en,latched,code}=%b expected %b", tag, obs, e);
        end
    endtask

    task automatic check_now(input logic [2:0] s, input logic [1:0] c, input string tag);
        exp_q.push_back(expect_word(s, c));
        check(tag);
    endtask

    task automatic tick(input logic [2:0] s, input logic [1:0] c, input string tag);
        exp_q.push_back(expect_word(s, c));
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        #12;
        check_now(3'd0, 2'd0, "reset");
        laser_ready = 1'b1;
        en_req      = 1'b1;
        tick(3'd0, 2'd0, "reset_hold");
        laser_ready = 1'b0;
        en_req      = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 49; i++) tick(3'd0, 2'd0, "powerup_wait");
        laser_ready = 1'b1;
        tick(3'd1, 2'd0, "powerup_idle");

        en_req = 1'b1;
        for (int i = 0; i < 30; i++) tick(3'd2, 2'd0, "shot_on");
        for (int i = 0; i < 20; i++) begin
            en_req = (i >= 3 && i < 15);
            tick(3'd4, 2'd0, "shot_cool");
        end
        en_req = 1'b0;
        tick(3'd1, 2'd0, "shot_idle");

        en_req = 1'b1;
        tick(3'd2, 2'd0, "maxon_enter");
        for (int j = 0; j < 100; j++) begin
            heartbeat = (j % 5 == 0);
            tick(j == 99 ? 3'd3 : 3'd2, j == 99 ? 2'd2 : 2'd0, "maxon_run");
        end
        heartbeat   = 1'b0;
        clear_fault = 1'b1;
        tick(3'd3, 2'd2, "clear_with_req");
        en_req  = 1'b0;
        fault_n = 1'b0;
        tick(3'd3, 2'd2, "clear_with_intlk");
        clear_fault = 1'b0;
        fault_n     = 1'b1;
        laser_ready = 1'b0;
        tick(3'd3, 2'd2, "fault_ign_ready");
        laser_ready = 1'b1;
        clear_fault = 1'b1;
        tick(3'd4, 2'd2, "clear_ok");
        clear_fault = 1'b0;
        for (int i = 0; i < 19; i++) tick(3'd4, 2'd2, "maxon_cool");
        tick(3'd1, 2'd2, "maxon_idle");

        en_req = 1'b1;
        tick(3'd2, 2'd2, "simul_enter");
        for (int j = 0; j < 9; j++) tick(3'd2, 2'd2, "simul_on");
        fault_n = 1'b0;
        tick(3'd3, 2'd1, "simul_fault");
        fault_n     = 1'b1;
        en_req      = 1'b0;
        clear_fault = 1'b1;
        tick(3'd4, 2'd1, "simul_clear");
        clear_fault = 1'b0;
        tick(3'd4, 2'd1, "cool_a");
        tick(3'd4, 2'd1, "cool_b");
        fault_n     = 1'b0;
        laser_ready = 1'b0;
        tick(3'd3, 2'd1, "cool_prio");
        fault_n     = 1'b1;
        laser_ready = 1'b1;
        clear_fault = 1'b1;
        tick(3'd4, 2'd1, "cool_reclear");
        clear_fault = 1'b0;
        laser_ready = 1'b0;
        tick(3'd0, 2'd1, "cool_notready");
        laser_ready = 1'b1;
        tick(3'd1, 2'd1, "cool_back_idle");

        en_req = 1'b1;
        tick(3'd2, 2'd1, "wdt_enter");
        for (int j = 0; j < WD_LEN; j++) begin
            heartbeat = (j == 3);
            tick(j == WD_LEN - 1 ? 3'd3 : 3'd2, j == WD_LEN - 1 ? WD_CODE : 2'd1, "wdt_run");
        end
        heartbeat   = 1'b0;
        en_req      = 1'b0;
        clear_fault = 1'b1;
        tick(3'd4, WD_CODE, "wdt_clear");
        clear_fault = 1'b0;
        for (int i = 0; i < 19; i++) tick(3'd4, WD_CODE, "wdt_cool");
        tick(3'd1, WD_CODE, "wdt_idle");

        laser_ready = 1'b0;
        tick(3'd0, WD_CODE, "idle_notready");
        laser_ready = 1'b1;
        tick(3'd1, WD_CODE, "idle_ready");
        en_req  = 1'b1;
        fault_n = 1'b0;
        tick(3'd3, 2'd1, "idle_intlk");
        en_req      = 1'b0;
        fault_n     = 1'b1;
        clear_fault = 1'b1;
        tick(3'd4, 2'd1, "idle_clear");
        clear_fault = 1'b0;
        for (int i = 0; i < 19; i++) tick(3'd4, 2'd1, "idle_cool");
        tick(3'd1, 2'd1, "idle_back");

        en_req = 1'b1;
        tick(3'd2, 2'd1, "on_enter");
        tick(3'd2, 2'd1, "on_hold");
        laser_ready = 1'b0;
        tick(3'd0, 2'd1, "on_notready");
        en_req      = 1'b0;
        laser_ready = 1'b1;
        tick(3'd1, 2'd1, "on_ready_idle");

        en_req    = 1'b1;
        heartbeat = 1'b1;
        for (int i = 0; i < 40; i++) tick(3'd2, 2'd1, "rst_on");
        rstn = 1'b0;
        #1;
        check_now(3'd0, 2'd0, "rst_async");
        tick(3'd0, 2'd0, "rst_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/laser_interlock.md
LASER_INTERLOCK -- requirements
Module: laser_interlock

Interface
REQ-001 SHALL have parameter MAX_ON_CYCLES, default 32'd50_000_000, the maximum number of continuous laser-on cycles.
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 32'd10_000_000, the mandatory number of laser-off cycles after any on period or fault.
REQ-003 SHALL have parameter WDT_CYCLES, default 24'd1_000_000, the heartbeat timeout in cycles.
REQ-004 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port laser_ready  input  1  power-up delay complete, from the laser reset sequencer.
REQ-007 SHALL have port en_req  input  1  level request for laser emission from the host.
REQ-008 SHALL have port fault_n  input  1  external interlock, active-low, pre-synchronised.
REQ-009 SHALL have port heartbeat  input  1  single-cycle host keep-alive pulse.
REQ-010 SHALL have port clear_fault  input  1  single-cycle host fault acknowledge.
REQ-011 SHALL have port laser_en  output  1  registered laser drive enable.
REQ-012 SHALL have port fault_latched  output  1  high while the FSM is in FAULT.
REQ-013 SHALL have port fault_code  output  2  cause of the last fault: 0 none, 1 interlock, 2 max-on, 3 watchdog.
REQ-014 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-015 SHALL implement the FSM states WAIT_RDY=0, IDLE=1, ON=2, FAULT=3, COOLDOWN=4; all other encodings SHALL go to FAULT with code 1 on the next edge.
REQ-016 SHALL drive laser_en high if and only if state==ON, with laser_en registered so it rises on the same edge that ON is entered.
REQ-017 WAIT_RDY: SHALL go to IDLE on the first edge where laser_ready=1.
REQ-018 IDLE: SHALL go to ON when en_req=1, fault_n=1 and laser_ready=1 are all true on the same edge, giving 1 cycle latency from request to laser_en.
REQ-019 ON: SHALL evaluate exit conditions with the priority fault_n=0 (FAULT, code 1) > watchdog expiry (FAULT, code 3) > max-on expiry (FAULT, code 2) > laser_ready=0 (WAIT_RDY) > en_req=0 (COOLDOWN).
REQ-020 SHALL clear the 32-bit on_cnt on entry to ON, increment it each ON cycle, and expire max-on when on_cnt==MAX_ON_CYCLES-1, so laser_en is high for exactly MAX_ON_CYCLES cycles at most.
REQ-021 COOLDOWN: SHALL clear the 32-bit cool_cnt on entry, go to IDLE when cool_cnt==COOLDOWN_CYCLES-1 (exactly COOLDOWN_CYCLES cycles spent), and ignore en_req throughout.
REQ-022 COOLDOWN: fault_n=0 SHALL go to FAULT with code 1; laser_ready=0 SHALL go to WAIT_RDY; fault_n SHALL take priority over laser_ready.
REQ-023 IDLE: fault_n=0 SHALL go to FAULT with code 1; laser_ready=0 SHALL go to WAIT_RDY.
REQ-024 FAULT: SHALL hold fault_latched=1 and ignore laser_ready.
REQ-025 FAULT: SHALL go to COOLDOWN only when clear_fault=1, fault_n=1 and en_req=0 on the same edge; a clear_fault pulse that does not meet these conditions SHALL be discarded.
REQ-026 SHALL hold fault_code until the next fault overwrites it or reset clears it; leaving FAULT SHALL NOT clear fault_code.
REQ-027 Counters SHALL saturate rather than wrap, and a parameter value of 0 SHALL be treated as 1.

Reset
REQ-028 On rstn=0 the block SHALL asynchronously force state=WAIT_RDY, laser_en=0, fault_latched=0, fault_code=0, and all counters to 0.
REQ-029 A reset asserted while in ON SHALL drop laser_en within the same reset assertion, with no clock edge required.

Configuration
REQ-030 With macro LASER_INTERLOCK_WDT_EN defined, the 24-bit wdt_cnt SHALL clear on ON entry and on any ON cycle with heartbeat=1, and SHALL expire when wdt_cnt==WDT_CYCLES-1 and heartbeat=0.
REQ-031 Without LASER_INTERLOCK_WDT_EN, no watchdog logic SHALL exist, heartbeat SHALL be ignored, and fault_code 3 SHALL never occur.

Verification (MAX_ON=100, COOLDOWN=20, WDT=10)
REQ-032 Power-up: release rstn, then raise laser_ready at cycle 50 -> state=1 at cycle 51; laser_en=0 throughout.
REQ-033 Normal shot: en_req=1 for 30 cycles -> laser_en high 30 cycles starting 1 cycle after en_req; then exactly 20 cycles in COOLDOWN, then IDLE.
REQ-034 Max-on: hold en_req=1 with heartbeats every 5 cycles -> laser_en high exactly 100 cycles, FAULT with fault_code=2; clear_fault while en_req=1 is ignored; clear_fault with en_req=0 -> COOLDOWN.
REQ-035 Interlock with watchdog simultaneous: in ON, fault_n=0 on the same edge as watchdog expiry -> FAULT with fault_code=1, laser_en low on the next edge.
REQ-036 Watchdog (macro defined): last heartbeat at ON cycle 3 -> FAULT with code 3 after 10 further cycles; macro undefined -> no fault until max-on.
REQ-037 Reset mid-ON: assert rstn=0 at ON cycle 40 -> laser_en=0 immediately; state=0 and fault_code=0.
